// File: rtl/fifo1_ptr.sv
// Wrap-bit pointer counter: the low bits address the memory, the MSB toggles on each pass.
module fifo1_ptr #(
  parameter int PW = 4
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          clr,
  input  logic          inc,
  output logic [PW-1:0] ptr
);

  logic [PW-1:0] r_ptr;

  always_ff @(posedge clk) begin
    if (!rstn)     r_ptr <= '0;
    else if (clr)  r_ptr <= '0;
    else if (inc)  r_ptr <= r_ptr + PW'(1);
  end

  assign ptr = r_ptr;

endmodule

// File: rtl/fifo1.sv
// Single-clock synchronous FIFO with full-depth usage, occupancy/threshold flags,
// optional first-word-fall-through reads, synchronous flush and sticky error flags.
module fifo1 #(
  parameter int W      = 8,
  parameter int L      = 8,
  parameter int FWFT   = 0,
  parameter int AF_LVL = L - 2,
  parameter int AE_LVL = 2
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 clr,
  input  logic                 w_en,
  input  logic [W-1:0]         data_in,
  input  logic                 r_en,
  output logic [W-1:0]         data_out,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic [$clog2(L):0]   count,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int AW = $clog2(L);
  localparam int PW = AW + 1;

  logic [W-1:0]  r_mem [L];
  logic [PW-1:0] w_wptr;
  logic [PW-1:0] w_rptr;
  logic          w_wr_acc;
  logic          w_rd_acc;
  logic          r_ovf;
  logic          r_unf;

  // Acceptance uses this cycle's registered flags; a flush suppresses both sides.
  assign w_wr_acc = w_en & ~full  & ~clr & rstn;
  assign w_rd_acc = r_en & ~empty & ~clr & rstn;

  fifo1_ptr #(.PW(PW)) u_wptr (
    .clk  (clk),
    .rstn (rstn),
    .clr  (clr),
    .inc  (w_wr_acc),
    .ptr  (w_wptr)
  );

  fifo1_ptr #(.PW(PW)) u_rptr (
    .clk  (clk),
    .rstn (rstn),
    .clr  (clr),
    .inc  (w_rd_acc),
    .ptr  (w_rptr)
  );

  assign empty        = (w_wptr == w_rptr);
  assign full         = (w_wptr[AW] != w_rptr[AW]) && (w_wptr[AW-1:0] == w_rptr[AW-1:0]);
  assign count        = w_wptr - w_rptr;
  assign almost_full  = (count >= PW'(AF_LVL));
  assign almost_empty = (count <= PW'(AE_LVL));

  always_ff @(posedge clk) begin
    if (w_wr_acc) r_mem[w_wptr[AW-1:0]] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (!rstn || clr) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      if (w_en && full)  r_ovf <= 1'b1;
      if (r_en && empty) r_unf <= 1'b1;
    end
  end

  assign overflow  = r_ovf;
  assign underflow = r_unf;

  generate
    if (FWFT != 0) begin : g_fwft
      assign data_out = empty ? '0 : r_mem[w_rptr[AW-1:0]];
    end else begin : g_reg
      logic [W-1:0] r_dout;
      // Holds across flush; only an accepted read reloads it.
      always_ff @(posedge clk) begin
        if (!rstn)         r_dout <= '0;
        else if (w_rd_acc) r_dout <= r_mem[w_rptr[AW-1:0]];
      end
      assign data_out = r_dout;
    end
  endgenerate

endmodule

// File: tb/tb_fifo1.sv
// Directed bench for fifo1: registered-read instance (a_*) and FWFT instance (b_*), W=8, L=8.
module tb_fifo1;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_rstn = 1'b0, a_clr = 1'b0, a_wen = 1'b0, a_ren = 1'b0;
  logic [7:0] a_din = '0, a_dout;
  logic       a_full, a_empty, a_af, a_ae, a_ovf, a_unf;
  logic [3:0] a_cnt;

  logic       b_rstn = 1'b0, b_clr = 1'b0, b_wen = 1'b0, b_ren = 1'b0;
  logic [7:0] b_din = '0, b_dout;
  logic       b_full, b_empty, b_af, b_ae, b_ovf, b_unf;
  logic [3:0] b_cnt;

  int total = 0;
  int bad   = 0;

  fifo1 #(.W(8), .L(8), .FWFT(0), .AF_LVL(6), .AE_LVL(2)) u_a (
    .clk(clk), .rstn(a_rstn), .clr(a_clr), .w_en(a_wen), .data_in(a_din), .r_en(a_ren),
    .data_out(a_dout), .full(a_full), .empty(a_empty), .almost_full(a_af),
    .almost_empty(a_ae), .count(a_cnt), .overflow(a_ovf), .underflow(a_unf)
  );

  fifo1 #(.W(8), .L(8), .FWFT(1), .AF_LVL(6), .AE_LVL(2)) u_b (
    .clk(clk), .rstn(b_rstn), .clr(b_clr), .w_en(b_wen), .data_in(b_din), .r_en(b_ren),
    .data_out(b_dout), .full(b_full), .empty(b_empty), .almost_full(b_af),
    .almost_empty(b_ae), .count(b_cnt), .overflow(b_ovf), .underflow(b_unf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    a_rstn = 1'b0; b_rstn = 1'b0;
    tick(); tick();
    a_rstn = 1'b1; b_rstn = 1'b1;
    total++; if (a_cnt !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", a_cnt); end
    total++; if (a_empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b exp=1", a_empty); end
    total++; if (a_full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", a_full); end
    total++; if (a_ae !== 1'b1) begin bad++; $display("FAIL reset_ae got=%b exp=1", a_ae); end
    total++; if (a_af !== 1'b0) begin bad++; $display("FAIL reset_af got=%b exp=0", a_af); end
    total++; if (a_ovf !== 1'b0 || a_unf !== 1'b0) begin bad++; $display("FAIL reset_err got=%b%b exp=00", a_ovf, a_unf); end
    total++; if (a_dout !== 8'h00) begin bad++; $display("FAIL reset_dout_a got=%h exp=00", a_dout); end
    total++; if (b_dout !== 8'h00 || b_empty !== 1'b1) begin bad++; $display("FAIL reset_b got=%h/%b exp=00/1", b_dout, b_empty); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 8; i++) begin
      a_wen = 1'b1; a_din = 8'h10 + 8'(i);
      tick();
      total++; if (a_cnt !== 4'(i + 1)) begin bad++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, a_cnt, i + 1); end
      total++; if (a_af !== (i + 1 >= 6)) begin bad++; $display("FAIL fill_af[%0d] got=%b exp=%b", i, a_af, (i + 1 >= 6)); end
      total++; if (a_full !== (i == 7)) begin bad++; $display("FAIL fill_full[%0d] got=%b exp=%b", i, a_full, (i == 7)); end
      total++; if (a_ae !== (i + 1 <= 2)) begin bad++; $display("FAIL fill_ae[%0d] got=%b exp=%b", i, a_ae, (i + 1 <= 2)); end
      total++; if (a_empty !== 1'b0) begin bad++; $display("FAIL fill_empty[%0d] got=%b exp=0", i, a_empty); end
    end
    a_din = 8'hFF;
    tick();
    a_wen = 1'b0;
    total++; if (a_ovf !== 1'b1) begin bad++; $display("FAIL fill_overflow got=%b exp=1", a_ovf); end
    total++; if (a_cnt !== 4'd8) begin bad++; $display("FAIL fill_count_after_ovf got=%0d exp=8", a_cnt); end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 8; i++) begin
      a_ren = 1'b1;
      tick();
      total++; if (a_dout !== 8'h10 + 8'(i)) begin bad++; $display("FAIL drain_data[%0d] got=%h exp=%h", i, a_dout, 8'h10 + 8'(i)); end
      total++; if (a_cnt !== 4'(7 - i)) begin bad++; $display("FAIL drain_count[%0d] got=%0d exp=%0d", i, a_cnt, 7 - i); end
      total++; if (a_empty !== (i == 7)) begin bad++; $display("FAIL drain_empty[%0d] got=%b exp=%b", i, a_empty, (i == 7)); end
    end
    tick();
    a_ren = 1'b0;
    total++; if (a_unf !== 1'b1) begin bad++; $display("FAIL drain_underflow got=%b exp=1", a_unf); end
    total++; if (a_dout !== 8'h17) begin bad++; $display("FAIL drain_hold got=%h exp=17", a_dout); end
    total++; if (a_ovf !== 1'b1) begin bad++; $display("FAIL drain_ovf_sticky got=%b exp=1", a_ovf); end
  endtask

  task automatic test_fwft();
    b_wen = 1'b1; b_din = 8'hA5;
    tick();
    b_wen = 1'b0;
    total++; if (b_empty !== 1'b0) begin bad++; $display("FAIL fwft_empty got=%b exp=0", b_empty); end
    total++; if (b_dout !== 8'hA5) begin bad++; $display("FAIL fwft_data got=%h exp=a5", b_dout); end
    b_ren = 1'b1;
    tick();
    b_ren = 1'b0;
    total++; if (b_empty !== 1'b1 || b_dout !== 8'h00) begin bad++; $display("FAIL fwft_pop got=%b/%h exp=1/00", b_empty, b_dout); end
    b_wen = 1'b1; b_din = 8'h11; tick();
    b_din = 8'h22; tick();
    b_wen = 1'b0;
    total++; if (b_dout !== 8'h11 || b_cnt !== 4'd2) begin bad++; $display("FAIL fwft_head got=%h/%0d exp=11/2", b_dout, b_cnt); end
    b_ren = 1'b1; tick();
    total++; if (b_dout !== 8'h22) begin bad++; $display("FAIL fwft_next got=%h exp=22", b_dout); end
    tick();
    b_ren = 1'b0;
    total++; if (b_dout !== 8'h00 || b_empty !== 1'b1) begin bad++; $display("FAIL fwft_drained got=%h/%b exp=00/1", b_dout, b_empty); end
    b_ren = 1'b1; tick(); b_ren = 1'b0;
    total++; if (b_unf !== 1'b1 || b_ovf !== 1'b0) begin bad++; $display("FAIL fwft_err got=%b%b exp=01", b_ovf, b_unf); end
  endtask

  task automatic test_wrap();
    a_clr = 1'b1; tick(); a_clr = 1'b0;
    total++; if (a_ovf !== 1'b0 || a_unf !== 1'b0) begin bad++; $display("FAIL wrap_clr_err got=%b%b exp=00", a_ovf, a_unf); end
    for (int i = 0; i < 3; i++) begin
      a_wen = 1'b1; a_din = 8'h30 + 8'(i); tick();
    end
    total++; if (a_cnt !== 4'd3) begin bad++; $display("FAIL wrap_prefill got=%0d exp=3", a_cnt); end
    for (int i = 0; i < 20; i++) begin
      a_wen = 1'b1; a_ren = 1'b1; a_din = 8'h33 + 8'(i);
      tick();
      total++; if (a_dout !== 8'h30 + 8'(i)) begin bad++; $display("FAIL wrap_data[%0d] got=%h exp=%h", i, a_dout, 8'h30 + 8'(i)); end
      total++; if (a_cnt !== 4'd3 || a_empty !== 1'b0 || a_full !== 1'b0) begin bad++; $display("FAIL wrap_flags[%0d] got=%0d/%b/%b exp=3/0/0", i, a_cnt, a_empty, a_full); end
      total++; if (a_ovf !== 1'b0 || a_unf !== 1'b0 || a_ae !== 1'b0 || a_af !== 1'b0) begin bad++; $display("FAIL wrap_err[%0d] got=%b%b%b%b exp=0000", i, a_ovf, a_unf, a_ae, a_af); end
    end
    a_wen = 1'b0; a_ren = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (a_dout !== 8'h44 + 8'(i)) begin bad++; $display("FAIL wrap_tail[%0d] got=%h exp=%h", i, a_dout, 8'h44 + 8'(i)); end
    end
    a_ren = 1'b0;
  endtask

  task automatic test_full_rw();
    a_clr = 1'b1; tick(); a_clr = 1'b0;
    for (int i = 0; i < 8; i++) begin
      a_wen = 1'b1; a_din = 8'h40 + 8'(i); tick();
    end
    total++; if (a_full !== 1'b1) begin bad++; $display("FAIL frw_full got=%b exp=1", a_full); end
    a_wen = 1'b1; a_ren = 1'b1; a_din = 8'hEE;
    tick();
    a_wen = 1'b0;
    total++; if (a_cnt !== 4'd7 || a_full !== 1'b0) begin bad++; $display("FAIL frw_count got=%0d/%b exp=7/0", a_cnt, a_full); end
    total++; if (a_ovf !== 1'b1) begin bad++; $display("FAIL frw_overflow got=%b exp=1", a_ovf); end
    total++; if (a_dout !== 8'h40) begin bad++; $display("FAIL frw_data got=%h exp=40", a_dout); end
    for (int i = 1; i < 8; i++) begin
      tick();
      total++; if (a_dout !== 8'h40 + 8'(i)) begin bad++; $display("FAIL frw_drain[%0d] got=%h exp=%h", i, a_dout, 8'h40 + 8'(i)); end
    end
    total++; if (a_empty !== 1'b1) begin bad++; $display("FAIL frw_empty got=%b exp=1", a_empty); end
    tick();
    a_ren = 1'b0;
    total++; if (a_unf !== 1'b1) begin bad++; $display("FAIL frw_underflow got=%b exp=1", a_unf); end
  endtask

  task automatic test_clr();
    for (int i = 0; i < 5; i++) begin
      a_wen = 1'b1; a_din = 8'h50 + 8'(i); tick();
    end
    total++; if (a_cnt !== 4'd5) begin bad++; $display("FAIL clr_pre got=%0d exp=5", a_cnt); end
    a_clr = 1'b1; a_wen = 1'b1; a_din = 8'h99;
    tick();
    a_clr = 1'b0;
    total++; if (a_cnt !== 4'd0 || a_empty !== 1'b1) begin bad++; $display("FAIL clr_state got=%0d/%b exp=0/1", a_cnt, a_empty); end
    total++; if (a_ovf !== 1'b0 || a_unf !== 1'b0) begin bad++; $display("FAIL clr_err got=%b%b exp=00", a_ovf, a_unf); end
    total++; if (a_dout !== 8'h47) begin bad++; $display("FAIL clr_hold got=%h exp=47", a_dout); end
    a_din = 8'h77;
    tick();
    a_wen = 1'b0;
    total++; if (a_cnt !== 4'd1) begin bad++; $display("FAIL clr_post_write got=%0d exp=1", a_cnt); end
    a_ren = 1'b1; tick(); a_ren = 1'b0;
    total++; if (a_dout !== 8'h77 || a_empty !== 1'b1) begin bad++; $display("FAIL clr_post_read got=%h/%b exp=77/1", a_dout, a_empty); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_fwft();
    test_wrap();
    test_full_rw();
    test_clr();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
